// File: rtl/csa_resolver_pkg.sv
// Shared types and helpers for the carry-save resolver.
// Exports csa_state_e and cnt_width() for sizing chunk counters.
package csa_resolver_pkg;

    typedef enum logic [1:0] {
        CSA_IDLE,
        CSA_BUSY,
        CSA_DONE
    } csa_state_e;

    // $clog2 yields 0 for n==1; a counter still needs one bit.
    function automatic int cnt_width(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/csa_resolver_chunk_adder.sv
// Combinational CW-bit adder used for one chunk of the resolve.
// Ports: a, b (CW), cin -> s (CW), cout.
module csa_chunk_adder #(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          cin,
    output logic [CW-1:0] s,
    output logic          cout
);

    logic [CW:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, cin};
        s     = total[CW-1:0];
        cout  = total[CW];
    end

endmodule

// File: rtl/csa_resolver.sv
// Resolves a carry-save sum/carry pair into binary, CW bits per cycle.
// Ports: clk_i, rst_ni, in_valid_i/in_ready_o, sum_i, carry_i,
//   out_valid_o/out_ready_i, result_o, cout_o.
// Macro CSA_RESOLVER_ZERO_SKIP_EN: finish early once upper bits are zero.
module csa_resolver
    import csa_resolver_pkg::*;
#(
    parameter int DW = 16,
    parameter int CW = 4
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] sum_i,
    input  logic [DW-1:0] carry_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] result_o,
    output logic          cout_o
);

    localparam int NCHUNK = DW / CW;
    localparam int CNTW   = cnt_width(NCHUNK);

    if (DW % CW != 0) begin : g_bad_cw
        $error("csa_resolver: DW must be a multiple of CW");
    end

    csa_state_e      state_q;
    logic [CNTW-1:0] cnt_q;
    logic [DW-1:0]   sum_q;
    logic [DW-1:0]   car_q;
    logic [DW-1:0]   res_q;
    logic            cin_q;
    logic            cout_q;
    logic            in_rdy_q;
    logic            out_vld_q;

    logic [CW-1:0]   a_c;
    logic [CW-1:0]   b_c;
    logic [CW-1:0]   s_c;
    logic            co_c;
    logic            done_c;
    logic [DW-1:0]   res_nxt;

    csa_chunk_adder #(.CW(CW)) u_add (
        .a    (a_c),
        .b    (b_c),
        .cin  (cin_q),
        .s    (s_c),
        .cout (co_c)
    );

    always_comb begin
        a_c     = sum_q[int'(cnt_q)*CW +: CW];
        b_c     = car_q[int'(cnt_q)*CW +: CW];
        res_nxt = res_q;
        res_nxt[int'(cnt_q)*CW +: CW] = s_c;
        done_c  = (int'(cnt_q) == NCHUNK - 1);
`ifdef CSA_RESOLVER_ZERO_SKIP_EN
        // No carry out and nothing left above: the rest is zero.
        if (!co_c && (((sum_q | car_q) >> ((int'(cnt_q) + 1) * CW)) == '0)) begin
            done_c  = 1'b1;
            res_nxt = res_nxt & ~({DW{1'b1}} << ((int'(cnt_q) + 1) * CW));
        end
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= CSA_IDLE;
            cnt_q     <= '0;
            sum_q     <= '0;
            car_q     <= '0;
            res_q     <= '0;
            cin_q     <= 1'b0;
            cout_q    <= 1'b0;
            in_rdy_q  <= 1'b1;
            out_vld_q <= 1'b0;
        end else begin
            unique case (state_q)
                CSA_IDLE: begin
                    if (in_valid_i) begin
                        sum_q    <= sum_i;
                        car_q    <= carry_i;
                        cnt_q    <= '0;
                        cin_q    <= 1'b0;
                        in_rdy_q <= 1'b0;
                        state_q  <= CSA_BUSY;
                    end
                end
                CSA_BUSY: begin
                    res_q <= res_nxt;
                    cin_q <= co_c;
                    cnt_q <= cnt_q + 1'b1;
                    if (done_c) begin
                        cout_q    <= co_c;
                        out_vld_q <= 1'b1;
                        state_q   <= CSA_DONE;
                    end
                end
                CSA_DONE: begin
                    if (out_ready_i) begin
                        out_vld_q <= 1'b0;
                        in_rdy_q  <= 1'b1;
                        state_q   <= CSA_IDLE;
                    end
                end
                default: begin
                    out_vld_q <= 1'b0;
                    in_rdy_q  <= 1'b1;
                    state_q   <= CSA_IDLE;
                end
            endcase
        end
    end

    assign in_ready_o  = in_rdy_q;
    assign out_valid_o = out_vld_q;
    assign result_o    = res_q;
    assign cout_o      = cout_q;

endmodule

// File: tb/tb_csa_resolver.sv
// Self-checking bench for csa_resolver (DW=16, CW=4).
// Randomized transactions compared against an arithmetic reference.
module tb_csa_resolver;

    localparam int DW     = 16;
    localparam int CW     = 4;
    localparam int NCHUNK = DW / CW;
    localparam int BUDGET = 40;
`ifdef CSA_RESOLVER_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [DW-1:0] sum_i = '0;
    logic [DW-1:0] carry_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [DW-1:0] result_o;
    logic          cout_o;

    int tests = 0;
    int fails = 0;

    csa_resolver #(.DW(DW), .CW(CW)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sum_i       (sum_i),
        .carry_i     (carry_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .cout_o      (cout_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [DW:0] ref_sum(logic [DW-1:0] a, logic [DW-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    // Early finish at k chunks when the low k*CW bits produce no carry
    // and both operands are zero above them.
    function automatic int exp_lat(logic [DW-1:0] a, logic [DW-1:0] b);
        for (int k = 1; k < NCHUNK; k++) begin
            int unsigned m;
            int unsigned lo;
            m  = (32'd1 << (k * CW)) - 1;
            lo = (32'(a) & m) + (32'(b) & m);
            if (SKIP && (lo >> (k * CW)) == 0 && (32'(a | b) >> (k * CW)) == 0)
                return k;
        end
        return NCHUNK;
    endfunction

    task automatic accept(input logic [DW-1:0] a, input logic [DW-1:0] b);
        int w;
        w = 0;
        while (!in_ready_o && w < BUDGET) begin
            @(posedge clk_i); #1;
            w++;
        end
        sum_i      = a;
        carry_i    = b;
        in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        sum_i      = DW'($urandom);
        carry_i    = DW'($urandom);
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid_o && lat < BUDGET) begin
            @(posedge clk_i); #1;
            lat++;
        end
    endtask

    task automatic release_out();
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        tests++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 ||
            result_o !== '0 || cout_o !== 1'b0) begin
            fails++;
            $display("FAIL reset: rdy=%b vld=%b res=%h cout=%b, want 1 0 0000 0",
                     in_ready_o, out_valid_o, result_o, cout_o);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] av [2];
        logic [DW-1:0] bv [2];
        int lat;
        logic [DW:0] e;
        av[0] = 16'h00FF; bv[0] = 16'h0001;
        av[1] = 16'hFFFF; bv[1] = 16'h0001;
        for (int i = 0; i < 2; i++) begin
            e = ref_sum(av[i], bv[i]);
            accept(av[i], bv[i]);
            tests++;
            if (in_ready_o !== 1'b0) begin
                fails++;
                $display("FAIL basic%0d busy_ready: got %b want 0", i, in_ready_o);
            end
            wait_valid(lat);
            tests++;
            if (lat != exp_lat(av[i], bv[i])) begin
                fails++;
                $display("FAIL basic%0d latency: got %0d want %0d",
                         i, lat, exp_lat(av[i], bv[i]));
            end
            tests++;
            if (result_o !== e[DW-1:0] || cout_o !== e[DW]) begin
                fails++;
                $display("FAIL basic%0d result: got %h/%b want %h/%b",
                         i, result_o, cout_o, e[DW-1:0], e[DW]);
            end
            release_out();
            tests++;
            if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
                fails++;
                $display("FAIL basic%0d handshake: vld=%b rdy=%b want 0 1",
                         i, out_valid_o, in_ready_o);
            end
        end
    endtask

    task automatic test_stall();
        int lat;
        logic [DW:0] e;
        e = ref_sum(16'h1357, 16'h2468);
        accept(16'h1357, 16'h2468);
        wait_valid(lat);
        for (int c = 0; c < 5; c++) begin
            in_valid_i = ~in_valid_i;
            sum_i      = DW'($urandom);
            @(posedge clk_i); #1;
            tests++;
            if (result_o !== e[DW-1:0] || cout_o !== e[DW] ||
                in_ready_o !== 1'b0 || out_valid_o !== 1'b1) begin
                fails++;
                $display("FAIL stall%0d: res=%h cout=%b rdy=%b vld=%b want %h %b 0 1",
                         c, result_o, cout_o, in_ready_o, out_valid_o,
                         e[DW-1:0], e[DW]);
            end
        end
        in_valid_i = 1'b0;
        release_out();
        tests++;
        if (out_valid_o !== 1'b0 || result_o !== e[DW-1:0]) begin
            fails++;
            $display("FAIL stall_release: vld=%b res=%h want 0 %h",
                     out_valid_o, result_o, e[DW-1:0]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        accept(16'hFFFF, 16'hFFFF);
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        #1;
        tests++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 ||
            result_o !== '0 || cout_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: rdy=%b vld=%b res=%h cout=%b want 1 0 0000 0",
                     in_ready_o, out_valid_o, result_o, cout_o);
        end
        #5;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        tests++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: rdy=%b vld=%b want 1 0",
                     in_ready_o, out_valid_o);
        end
        accept(16'h1234, 16'h0F0F);
        wait_valid(lat);
        tests++;
        if (result_o !== 16'h2143 || cout_o !== 1'b0 ||
            lat != exp_lat(16'h1234, 16'h0F0F)) begin
            fails++;
            $display("FAIL after_reset: res=%h cout=%b lat=%0d want 2143 0 %0d",
                     result_o, cout_o, lat, exp_lat(16'h1234, 16'h0F0F));
        end
        release_out();
    endtask

`ifdef CSA_RESOLVER_ZERO_SKIP_EN
    task automatic test_zero_skip();
        logic [DW-1:0] av [3];
        logic [DW-1:0] bv [3];
        logic [DW:0]   ev [3];
        int            lv [3];
        int            lat;
        av[0] = 16'h0003; bv[0] = 16'h0001; ev[0] = 17'h00004; lv[0] = 1;
        av[1] = 16'h0000; bv[1] = 16'h0000; ev[1] = 17'h00000; lv[1] = 1;
        av[2] = 16'h8000; bv[2] = 16'h8000; ev[2] = 17'h10000; lv[2] = 4;
        for (int i = 0; i < 3; i++) begin
            accept(av[i], bv[i]);
            wait_valid(lat);
            tests++;
            if (lat != lv[i] || result_o !== ev[i][DW-1:0] ||
                cout_o !== ev[i][DW]) begin
                fails++;
                $display("FAIL skip%0d: lat=%0d res=%h cout=%b want %0d %h %b",
                         i, lat, result_o, cout_o, lv[i],
                         ev[i][DW-1:0], ev[i][DW]);
            end
            release_out();
        end
    endtask
`endif

    task automatic test_random();
        int lat;
        int stall;
        int nchunk_live;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW:0]   e;
        for (int n = 0; n < 1000; n++) begin
            a = DW'($urandom);
            b = DW'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                nchunk_live = $urandom_range(0, NCHUNK);
                a = a & DW'((32'd1 << (nchunk_live * CW)) - 1);
                b = b & DW'((32'd1 << (nchunk_live * CW)) - 1);
            end
            e = ref_sum(a, b);
            accept(a, b);
            in_valid_i = $urandom_range(0, 1) == 1;
            wait_valid(lat);
            tests++;
            if (lat != exp_lat(a, b) || result_o !== e[DW-1:0] ||
                cout_o !== e[DW]) begin
                fails++;
                $display("FAIL rand%0d %h+%h: lat=%0d res=%h cout=%b want %0d %h %b",
                         n, a, b, lat, result_o, cout_o, exp_lat(a, b),
                         e[DW-1:0], e[DW]);
            end
            stall = $urandom_range(0, 3);
            for (int c = 0; c < stall; c++) begin
                @(posedge clk_i); #1;
            end
            if (stall > 0) begin
                tests++;
                if (out_valid_o !== 1'b1 || result_o !== e[DW-1:0]) begin
                    fails++;
                    $display("FAIL rand%0d stall: vld=%b res=%h want 1 %h",
                             n, out_valid_o, result_o, e[DW-1:0]);
                end
            end
            in_valid_i = 1'b0;
            release_out();
            tests++;
            if (out_valid_o !== 1'b0) begin
                fails++;
                $display("FAIL rand%0d dup: vld=%b want 0", n, out_valid_o);
            end
        end
    endtask

    initial begin
        #12;
        test_reset();
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        test_reset();
        test_basic();
        test_stall();
        test_reset_mid();
`ifdef CSA_RESOLVER_ZERO_SKIP_EN
        test_zero_skip();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
